char_anim_state_ctrl: RTL and testbench
=======================================

Name: char_anim_state_ctrl

Overview:
- Upstream neighbour of the character sprite display controller. Converts physics/control status into the sprite selector `char_id` and the facing `char_face` consumed by that controller.
- All visible changes are committed only on frame boundaries (`frame_tick`), so sprites never tear mid-frame.
- Level-driven pose candidates are debounced, removing single-frame sprite flicker.
- Handles idle two-frame alternation and fixed-length landing poses.

Parameters:
- DEBOUNCE_FRAMES, 2, consecutive frame_ticks a level-driven candidate must persist before commit (1 = immediate)
- IDLE_PERIOD, 30, frame_ticks per idle sprite before toggling IDLE_1/IDLE_2
- LAND_HOLD_FRAMES, 6, frame_ticks SAFE_GROUND is held after a normal landing
- FALL_HOLD_FRAMES, 20, frame_ticks FALL_TO_GROUND is held after a hard fall
- VY_WIDTH, 10, width of signed vertical velocity

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  reset, synchronous, active-low
- frame_tick  in  1  one-cycle pulse per video frame; the only update instant
- char_on_ground  in  1  level: character standing on a platform
- char_charging  in  1  level: jump charge held
- char_vy  in  VY_WIDTH signed  vertical velocity, positive = upward
- char_fell  in  1  one-cycle pulse, any cycle: hard fall detected
- char_dir  in  2 signed  2'b01 right, 2'b11 left, 2'b00 none, 2'b10 ignored
- char_id  out  3  0 IDLE_1, 1 IDLE_2, 2 CHARGE, 3 JUMP_UP, 4 JUMP_DOWN, 5 FALL_TO_GROUND, 6 SAFE_GROUND
- char_face  out  2 signed  2'b01 right, 2'b11 left
- id_changed  out  1  one-cycle pulse on the cycle after a tick that commits a new char_id

Behaviour:
- Reset (synchronous, active-low):
  - char_id=0, char_face=2'b01, id_changed=0
  - All counters 0; fell latch 0; was_airborne 0
  - Reset asserted mid-hold or mid-debounce aborts it; outputs take reset values at that clock edge.
- Fell latch:
  - char_fell sets the latch in any cycle.
  - The latch is consumed (cleared) on the next frame_tick.
  - A pulse coinciding with frame_tick is used by that tick.
- Registers update only on cycles with frame_tick=1, except the fell latch and id_changed; all outputs otherwise hold.
- Evaluation per tick, in priority order:
  1. Airborne (char_on_ground=0): level candidate JUMP_UP if char_vy>0, else JUMP_DOWN. Aborts any hold.
  2. On ground and fell latch set: commit FALL_TO_GROUND immediately (event, no debounce); hold_cnt=FALL_HOLD_FRAMES.
  3. On ground and was_airborne=1 (landing): commit SAFE_GROUND immediately; hold_cnt=LAND_HOLD_FRAMES.
  4. hold_cnt>0: decrement; char_id unchanged.
  5. char_charging: level candidate CHARGE.
  6. Otherwise: level candidate IDLE.
- Rules 2 and 3 in the same tick: FALL_TO_GROUND wins.
- was_airborne is updated every tick to !char_on_ground.
- Debounce (level candidates only):
  - stab_cnt counts consecutive ticks whose candidate equals pend_id and differs from char_id.
  - On reaching DEBOUNCE_FRAMES: commit, stab_cnt=0.
  - A candidate change resets stab_cnt to 1 with pend_id = new candidate.
  - A candidate equal to char_id clears stab_cnt.
  - IDLE matches either IDLE_1 or IDLE_2.
- Idle:
  - Committing into IDLE yields IDLE_1 with idle_cnt=0.
  - While idle, each tick increments idle_cnt; at IDLE_PERIOD-1, char_id toggles 0<->1, idle_cnt=0, id_changed pulses.
- A hold ending (hold_cnt reaching 0) returns to rule 5/6 evaluation on the next tick, debounced from the hold state.
- Facing:
  - On a tick with char_on_ground=1, char_charging=0, and char_dir ∈ {01, 11}: char_face=char_dir.
  - Otherwise face holds, i.e. frozen while airborne or charging.
- frame_tick held high for multiple cycles: each high cycle counts as a tick. Not a legal stimulus; not checked.

Optional Feature:
- Macro: CHAR_ID_FORCE_EN
- Defined: adds inputs force_en (1) and force_id (3).
  - While force_en=1, char_id=force_id is registered on each frame_tick.
  - Internal FSM, counters and face keep running.
  - Releasing force_en restores the internal char_id on the next tick.
  - force_id=7 is passed through unmodified.
- Undefined: no extra ports, no bypass logic.

Decomposition:
- Package char_anim_pkg: char_id encodings (IDLE_1..SAFE_GROUND, shared with the display controller), face encodings FACE_RIGHT=2'b01 and FACE_LEFT=2'b11, CHAR_ID_W=3.
- One sub-module, char_id_debouncer: pend_id/stab_cnt logic, parameterised by DEBOUNCE_FRAMES, with a tick enable. Holds, idle and face logic stay in the top.

Test Plan:
- Reset, then ground idle with IDLE_PERIOD=4, DEBOUNCE_FRAMES=2 → char_id 0 for 4 ticks, then 1, then 0 after 4 more; id_changed one cycle each toggle.
- char_charging high 1 tick then low → char_id stays 0. High 2 ticks → char_id=2 after 2nd tick.
- on_ground=0, vy=+5 for 2 ticks → 3; vy=-3 for 2 ticks → 4; on_ground=1 → 6 on that tick. With LAND_HOLD_FRAMES=3 it stays 6 through the hold, then IDLE_1 after debounce.
- char_fell pulse mid-frame, landing on the next tick → 5 (beats 6), held FALL_HOLD_FRAMES=8 ticks. on_ground=0 during hold → hold aborted, 3/4 after debounce.
- char_dir=11 on ground, idle → char_face=11 at next tick; char_dir=01 while airborne → face stays 11 until landed.
- sys_rst_n low one clock during FALL hold → next edge char_id=0, face=01, id_changed=0; fell latch cleared.

Source files
------------

// File: rtl/char_anim_pkg.sv
// Shared encodings for the character animation path.
// The char_id codes are also used by the sprite display controller.
package char_anim_pkg;

    localparam int CHAR_ID_W = 3;

    typedef enum logic [CHAR_ID_W-1:0] {
        IDLE_1         = 3'd0,
        IDLE_2         = 3'd1,
        CHARGE         = 3'd2,
        JUMP_UP        = 3'd3,
        JUMP_DOWN      = 3'd4,
        FALL_TO_GROUND = 3'd5,
        SAFE_GROUND    = 3'd6
    } char_id_e;

    localparam logic [1:0] FACE_RIGHT = 2'b01;
    localparam logic [1:0] FACE_LEFT  = 2'b11;

    // Both idle frames count as "idle" when comparing pose candidates.
    function automatic logic is_idle(input logic [CHAR_ID_W-1:0] id);
        return (id == IDLE_1) || (id == IDLE_2);
    endfunction

endpackage

// File: rtl/char_id_debouncer.sv
// Debounces level-driven pose candidates: a candidate must persist for
// DEBOUNCE_FRAMES consecutive frame ticks before it is committed.
module char_id_debouncer
    import char_anim_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 2
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 tick,
    input  logic                 cand_valid,
    input  logic [CHAR_ID_W-1:0] cand_id,
    input  logic [CHAR_ID_W-1:0] cur_id,
    output logic                 commit
);

    localparam int STAB_W = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [STAB_W-1:0] STAB_TARGET = STAB_W'(DEBOUNCE_FRAMES);
    localparam logic [STAB_W-1:0] STAB_ONE    = STAB_W'(1);

    logic [CHAR_ID_W-1:0] pend_id_reg, pend_id_next;
    logic [STAB_W-1:0]    stab_cnt_reg, stab_cnt_next;
    logic                 cand_matches_cur;
    logic                 commit_next;

    // Run-length of the pending candidate; ticks without a level candidate
    // (events, holds) break the run.
    always_comb begin
        cand_matches_cur = (cand_id == cur_id) || (is_idle(cand_id) && is_idle(cur_id));
        pend_id_next     = pend_id_reg;
        stab_cnt_next    = stab_cnt_reg;
        commit_next      = 1'b0;
        if (!cand_valid || cand_matches_cur) begin
            stab_cnt_next = '0;
        end else if ((stab_cnt_reg != '0) && (cand_id == pend_id_reg)) begin
            if ((stab_cnt_reg + STAB_ONE) == STAB_TARGET) begin
                commit_next   = 1'b1;
                stab_cnt_next = '0;
            end else begin
                stab_cnt_next = stab_cnt_reg + STAB_ONE;
            end
        end else begin
            pend_id_next = cand_id;
            if (STAB_ONE == STAB_TARGET) begin
                commit_next   = 1'b1;
                stab_cnt_next = '0;
            end else begin
                stab_cnt_next = STAB_ONE;
            end
        end
    end

    assign commit = tick & commit_next;

    // Debounce state advances only on frame ticks.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            pend_id_reg  <= IDLE_1;
            stab_cnt_reg <= '0;
        end else if (tick) begin
            pend_id_reg  <= pend_id_next;
            stab_cnt_reg <= stab_cnt_next;
        end
    end

endmodule

// File: rtl/char_anim_state_ctrl.sv
// Character animation state controller: turns physics/control status into
// the sprite selector char_id and facing char_face, committing changes only
// on frame ticks. Optional macro CHAR_ID_FORCE_EN adds a force_en/force_id
// override of the registered char_id output.
module char_anim_state_ctrl
    import char_anim_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES  = 2,
    parameter int IDLE_PERIOD      = 30,
    parameter int LAND_HOLD_FRAMES = 6,
    parameter int FALL_HOLD_FRAMES = 20,
    parameter int VY_WIDTH         = 10
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic                       frame_tick,
    input  logic                       char_on_ground,
    input  logic                       char_charging,
    input  logic signed [VY_WIDTH-1:0] char_vy,
    input  logic                       char_fell,
    input  logic signed [1:0]          char_dir,
`ifdef CHAR_ID_FORCE_EN
    input  logic                       force_en,
    input  logic [CHAR_ID_W-1:0]       force_id,
`endif
    output logic [CHAR_ID_W-1:0]       char_id,
    output logic signed [1:0]          char_face,
    output logic                       id_changed
);

    localparam int HOLD_MAX = (LAND_HOLD_FRAMES > FALL_HOLD_FRAMES) ? LAND_HOLD_FRAMES : FALL_HOLD_FRAMES;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam int IDLE_W   = (IDLE_PERIOD > 1) ? $clog2(IDLE_PERIOD) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAND = HOLD_W'(LAND_HOLD_FRAMES);
    localparam logic [HOLD_W-1:0] HOLD_FALL = HOLD_W'(FALL_HOLD_FRAMES);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_PERIOD - 1);
    localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);

    logic [CHAR_ID_W-1:0] id_reg, id_next;
    logic [CHAR_ID_W-1:0] char_id_reg, out_id_next;
    logic [1:0]           face_reg, face_next;
    logic                 id_changed_reg;
    logic [HOLD_W-1:0]    hold_cnt_reg, hold_next;
    logic [IDLE_W-1:0]    idle_cnt_reg, idle_next;
    logic                 fell_latch_reg;
    logic                 was_airborne_reg;

    logic                 vy_up;
    logic                 fell_now;
    logic                 cand_valid;
    logic [CHAR_ID_W-1:0] cand_id;
    logic                 rule_idle;
    logic                 deb_commit;

    assign vy_up    = !char_vy[VY_WIDTH-1] && (char_vy != '0);
    // A fall pulse on the tick cycle itself is honoured by that tick.
    assign fell_now = fell_latch_reg | char_fell;

    // Level-driven pose candidate for this tick (airborne, charge or idle).
    always_comb begin
        cand_valid = 1'b0;
        cand_id    = IDLE_1;
        rule_idle  = 1'b0;
        if (!char_on_ground) begin
            cand_valid = 1'b1;
            cand_id    = vy_up ? JUMP_UP : JUMP_DOWN;
        end else if (!fell_now && !was_airborne_reg && (hold_cnt_reg == '0)) begin
            cand_valid = 1'b1;
            if (char_charging) begin
                cand_id = CHARGE;
            end else begin
                cand_id   = IDLE_1;
                rule_idle = 1'b1;
            end
        end
    end

    char_id_debouncer #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_debouncer (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .tick       (frame_tick),
        .cand_valid (cand_valid),
        .cand_id    (cand_id),
        .cur_id     (id_reg),
        .commit     (deb_commit)
    );

    // Priority evaluation of the pose rules plus facing update.
    always_comb begin
        id_next   = id_reg;
        hold_next = hold_cnt_reg;
        idle_next = idle_cnt_reg;
        face_next = face_reg;
        if (!char_on_ground) begin
            hold_next = '0;
            if (deb_commit) begin
                id_next = cand_id;
            end
        end else if (fell_now) begin
            id_next   = FALL_TO_GROUND;
            hold_next = HOLD_FALL;
        end else if (was_airborne_reg) begin
            id_next   = SAFE_GROUND;
            hold_next = HOLD_LAND;
        end else if (hold_cnt_reg != '0) begin
            hold_next = hold_cnt_reg - HOLD_ONE;
        end else if (deb_commit) begin
            id_next = cand_id;
            if (rule_idle) begin
                idle_next = '0;
            end
        end else if (rule_idle && is_idle(id_reg)) begin
            if (idle_cnt_reg == IDLE_LAST) begin
                id_next   = (id_reg == IDLE_1) ? IDLE_2 : IDLE_1;
                idle_next = '0;
            end else begin
                idle_next = idle_cnt_reg + IDLE_ONE;
            end
        end
        if (char_on_ground && !char_charging &&
            ((char_dir == FACE_RIGHT) || (char_dir == FACE_LEFT))) begin
            face_next = char_dir;
        end
    end

`ifdef CHAR_ID_FORCE_EN
    assign out_id_next = force_en ? force_id : id_next;
`else
    assign out_id_next = id_next;
`endif

    // State register: everything advances on frame ticks, except the fall
    // latch (any cycle) and the one-cycle id_changed pulse.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            id_reg           <= IDLE_1;
            char_id_reg      <= IDLE_1;
            face_reg         <= FACE_RIGHT;
            id_changed_reg   <= 1'b0;
            hold_cnt_reg     <= '0;
            idle_cnt_reg     <= '0;
            fell_latch_reg   <= 1'b0;
            was_airborne_reg <= 1'b0;
        end else begin
            id_changed_reg <= 1'b0;
            fell_latch_reg <= fell_latch_reg | char_fell;
            if (frame_tick) begin
                id_reg           <= id_next;
                char_id_reg      <= out_id_next;
                id_changed_reg   <= (out_id_next != char_id_reg);
                face_reg         <= face_next;
                hold_cnt_reg     <= hold_next;
                idle_cnt_reg     <= idle_next;
                fell_latch_reg   <= 1'b0;
                was_airborne_reg <= !char_on_ground;
            end
        end
    end

    assign char_id    = char_id_reg;
    assign char_face  = face_reg;
    assign id_changed = id_changed_reg;

endmodule

// File: tb/tb_char_anim_state_ctrl.sv
// Self-checking bench for char_anim_state_ctrl (default build, no force port).
`timescale 1ns/1ps
module tb_char_anim_state_ctrl;

    localparam int DEB  = 2;
    localparam int IP   = 4;
    localparam int LAND = 3;
    localparam int FALL = 8;
    localparam int VW   = 10;

    logic                 sys_clk = 1'b0;
    logic                 sys_rst_n = 1'b0;
    logic                 frame_tick = 1'b0;
    logic                 char_on_ground = 1'b1;
    logic                 char_charging = 1'b0;
    logic signed [VW-1:0] char_vy = '0;
    logic                 char_fell = 1'b0;
    logic signed [1:0]    char_dir = 2'b00;
    logic [2:0]           char_id;
    logic signed [1:0]    char_face;
    logic                 id_changed;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state
    int     m_id, m_hold, m_idle, m_run, m_pend;
    bit     m_fell, m_air, m_changed;
    bit [1:0] m_face;

    always #5 sys_clk = ~sys_clk;

    char_anim_state_ctrl #(
        .DEBOUNCE_FRAMES  (DEB),
        .IDLE_PERIOD      (IP),
        .LAND_HOLD_FRAMES (LAND),
        .FALL_HOLD_FRAMES (FALL),
        .VY_WIDTH         (VW)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .frame_tick     (frame_tick),
        .char_on_ground (char_on_ground),
        .char_charging  (char_charging),
        .char_vy        (char_vy),
        .char_fell      (char_fell),
        .char_dir       (char_dir),
        .char_id        (char_id),
        .char_face      (char_face),
        .id_changed     (id_changed)
    );

    task automatic model_reset();
        m_id = 0; m_hold = 0; m_idle = 0; m_run = 0; m_pend = 0;
        m_fell = 0; m_air = 0; m_changed = 0; m_face = 2'b01;
    endtask

    // One frame evaluated straight from the pose rules.
    task automatic model_step(input bit og, input bit ch, input int vy, input bit [1:0] dir);
        int new_id, cand;
        bit lvl;
        new_id = m_id; cand = 0; lvl = 0;
        if (!og) begin lvl = 1; cand = (vy > 0) ? 3 : 4; m_hold = 0; end
        else if (m_fell) begin new_id = 5; m_hold = FALL; end
        else if (m_air) begin new_id = 6; m_hold = LAND; end
        else if (m_hold > 0) m_hold = m_hold - 1;
        else begin lvl = 1; cand = ch ? 2 : 0; end
        if (!lvl) m_run = 0;
        else if (cand == m_id || (cand == 0 && m_id <= 1)) begin
            m_run = 0;
            if (cand == 0) begin
                if (m_idle == IP - 1) begin new_id = 1 - m_id; m_idle = 0; end
                else m_idle = m_idle + 1;
            end
        end else begin
            if (m_run > 0 && cand == m_pend) m_run = m_run + 1;
            else begin m_pend = cand; m_run = 1; end
            if (m_run == DEB) begin new_id = cand; m_run = 0; if (cand == 0) m_idle = 0; end
        end
        if (og && !ch && (dir == 2'b01 || dir == 2'b11)) m_face = dir;
        m_air = !og; m_fell = 0;
        m_changed = (new_id != m_id);
        m_id = new_id;
    endtask

    // Drive one frame_tick cycle and step the model; sampled 1 ns after the edge.
    task automatic do_tick(input bit og, input bit ch, input int vy, input bit [1:0] dir, input bit fell);
        @(negedge sys_clk);
        char_on_ground = og; char_charging = ch; char_vy = VW'(vy);
        char_dir = dir; char_fell = fell; frame_tick = 1'b1;
        if (fell) m_fell = 1;
        @(posedge sys_clk); #1;
        frame_tick = 1'b0; char_fell = 1'b0;
        model_step(og, ch, vy, dir);
    endtask

    // Mid-frame hard-fall pulse.
    task automatic pulse_fell();
        @(negedge sys_clk); char_fell = 1'b1;
        @(negedge sys_clk); char_fell = 1'b0;
        m_fell = 1;
    endtask

    task automatic apply_reset();
        @(negedge sys_clk); sys_rst_n = 1'b0;
        @(posedge sys_clk); #1;
        model_reset();
        @(negedge sys_clk); sys_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (char_id !== 3'd0) begin n_fails++; $display("FAIL reset_id: got %0d want 0", char_id); end
        n_checks++; if (char_face !== 2'b01) begin n_fails++; $display("FAIL reset_face: got %b want 01", char_face); end
        n_checks++; if (id_changed !== 1'b0) begin n_fails++; $display("FAIL reset_changed: got %b want 0", id_changed); end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 2 * IP; i++) begin
            do_tick(1, 0, 0, 2'b00, 0);
            $display("idle tick %0d: id=%0d changed=%b", i, char_id, id_changed);
            n_checks++; if (char_id !== 3'(m_id)) begin n_fails++; $display("FAIL idle_id tick %0d: got %0d want %0d", i, char_id, m_id); end
            n_checks++; if (id_changed !== m_changed) begin n_fails++; $display("FAIL idle_changed tick %0d: got %b want %b", i, id_changed, m_changed); end
        end
        @(posedge sys_clk); #1;
        n_checks++; if (id_changed !== 1'b0) begin n_fails++; $display("FAIL idle_pulse_width: got %b want 0", id_changed); end
    endtask

    task automatic test_charge();
        bit ch_seq [5] = '{1, 0, 1, 1, 0};
        for (int i = 0; i < 5; i++) begin
            do_tick(1, ch_seq[i], 0, 2'b00, 0);
            $display("charge tick %0d: ch=%0d id=%0d", i, ch_seq[i], char_id);
            n_checks++; if (char_id !== 3'(m_id)) begin n_fails++; $display("FAIL charge_id tick %0d: got %0d want %0d", i, char_id, m_id); end
        end
    endtask

    task automatic test_jump_land();
        int og_seq [11] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
        int vy_seq [11] = '{5, 5, -3, -3, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 11; i++) begin
            do_tick(og_seq[i][0], 0, vy_seq[i], 2'b00, 0);
            $display("jump tick %0d: og=%0d vy=%0d id=%0d changed=%b", i, og_seq[i], vy_seq[i], char_id, id_changed);
            n_checks++; if (char_id !== 3'(m_id)) begin n_fails++; $display("FAIL jump_id tick %0d: got %0d want %0d", i, char_id, m_id); end
            n_checks++; if (id_changed !== m_changed) begin n_fails++; $display("FAIL jump_changed tick %0d: got %b want %b", i, id_changed, m_changed); end
        end
    endtask

    task automatic test_fall();
        do_tick(0, 0, 5, 2'b00, 0);
        do_tick(0, 0, 5, 2'b00, 0);
        pulse_fell();
        for (int i = 0; i < FALL + 3; i++) begin
            do_tick(1, 0, 0, 2'b00, 0);
            $display("fall hold tick %0d: id=%0d", i, char_id);
            n_checks++; if (char_id !== 3'(m_id)) begin n_fails++; $display("FAIL fall_hold_id tick %0d: got %0d want %0d", i, char_id, m_id); end
        end
        // fall pulse on the tick itself, then abort the hold by leaving the ground
        do_tick(1, 0, 0, 2'b00, 1);
        n_checks++; if (char_id !== 3'(m_id)) begin n_fails++; $display("FAIL fall_coincident_id: got %0d want %0d", char_id, m_id); end
        for (int i = 0; i < 4; i++) begin
            do_tick((i < 2) ? 1'b1 : 1'b0, 0, -3, 2'b00, 0);
            $display("fall abort tick %0d: id=%0d", i, char_id);
            n_checks++; if (char_id !== 3'(m_id)) begin n_fails++; $display("FAIL fall_abort_id tick %0d: got %0d want %0d", i, char_id, m_id); end
        end
    endtask

    task automatic test_face();
        int  og_seq  [5] = '{1, 0, 0, 1, 1};
        int  ch_seq  [5] = '{0, 0, 0, 0, 1};
        int  dir_seq [5] = '{3, 1, 1, 1, 3};
        for (int i = 0; i < 5; i++) begin
            do_tick(og_seq[i][0], ch_seq[i][0], -1, dir_seq[i][1:0], 0);
            $display("face tick %0d: dir=%0d face=%b", i, dir_seq[i], char_face);
            n_checks++; if (char_face !== m_face) begin n_fails++; $display("FAIL face tick %0d: got %b want %b", i, char_face, m_face); end
        end
        do_tick(1, 0, 0, 2'b10, 0);
        n_checks++; if (char_face !== m_face) begin n_fails++; $display("FAIL face_ignored_dir: got %b want %b", char_face, m_face); end
    endtask

    task automatic test_reset_mid_hold();
        do_tick(1, 0, 0, 2'b11, 1);
        do_tick(1, 0, 0, 2'b11, 0);
        n_checks++; if (char_id !== 3'd5) begin n_fails++; $display("FAIL pre_reset_id: got %0d want 5", char_id); end
        pulse_fell();
        apply_reset();
        $display("reset mid hold: id=%0d face=%b changed=%b", char_id, char_face, id_changed);
        n_checks++; if (char_id !== 3'd0) begin n_fails++; $display("FAIL midreset_id: got %0d want 0", char_id); end
        n_checks++; if (char_face !== 2'b01) begin n_fails++; $display("FAIL midreset_face: got %b want 01", char_face); end
        n_checks++; if (id_changed !== 1'b0) begin n_fails++; $display("FAIL midreset_changed: got %b want 0", id_changed); end
        do_tick(1, 0, 0, 2'b00, 0);
        n_checks++; if (char_id !== 3'(m_id)) begin n_fails++; $display("FAIL post_reset_latch_id: got %0d want %0d", char_id, m_id); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            int gap, vy;
            bit og, ch, fl;
            bit [1:0] dir;
            gap = int'($urandom_range(2));
            for (int g = 0; g < gap; g++) begin
                if ($urandom_range(9) == 0) pulse_fell();
                else @(negedge sys_clk);
            end
            og  = ($urandom_range(9) < 7);
            ch  = ($urandom_range(9) < 3);
            vy  = int'($urandom_range(40)) - 20;
            dir = 2'($urandom_range(3));
            fl  = ($urandom_range(19) == 0);
            do_tick(og, ch, vy, dir, fl);
            $display("rand tick %0d: og=%0d ch=%0d vy=%0d dir=%b fell=%0d id=%0d face=%b chg=%b",
                     i, og, ch, vy, dir, fl, char_id, char_face, id_changed);
            n_checks++; if (char_id !== 3'(m_id)) begin n_fails++; $display("FAIL rand_id tick %0d: got %0d want %0d", i, char_id, m_id); end
            n_checks++; if (char_face !== m_face) begin n_fails++; $display("FAIL rand_face tick %0d: got %b want %b", i, char_face, m_face); end
            n_checks++; if (id_changed !== m_changed) begin n_fails++; $display("FAIL rand_changed tick %0d: got %b want %b", i, id_changed, m_changed); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_idle();
        test_charge();
        test_jump_land();
        test_fall();
        test_face();
        test_reset_mid_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
